// File: rtl/alu_pipe.sv
// alu_pipe: two-stage WIDTH-bit ALU with valid/ready on both sides; 2-cycle latency, full-throughput
// backpressure (in_ready falls combinationally from out_ready); ALU_PIPE_SAT_EN enables saturating ADD/SUB/NEGA.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_PASSA = 3'd2,
    OP_PASSB = 3'd3,
    OP_NEGA  = 3'd4,
    OP_AND   = 3'd5,
    OP_OR    = 3'd6,
    OP_XOR   = 3'd7
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;
    logic             zero;
  } res_t;

  s1_t  s1_dat;
  logic s1_valid;
  res_t s2_nxt;
  logic adv1;
  logic adv2;
  logic accept;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1 && !reset;
  assign accept   = in_valid && in_ready;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             sat_hi;

  // Stage-2 datapath; sat_hi says which signed extreme the true result lies beyond.
  always_comb begin
    sum    = {1'b0, s1_dat.a} + {1'b0, s1_dat.b};
    diff   = {1'b0, s1_dat.a} - {1'b0, s1_dat.b};
    res    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    sat_hi = 1'b0;
    s2_nxt = '0;
    case (s1_dat.op)
      OP_ADD: begin
        res    = sum[MSB:0];
        carry  = sum[WIDTH];
        ovf    = (s1_dat.a[MSB] == s1_dat.b[MSB]) && (sum[MSB] != s1_dat.a[MSB]);
        sat_hi = !s1_dat.a[MSB];
      end
      OP_SUB: begin
        res    = diff[MSB:0];
        carry  = diff[WIDTH];
        ovf    = (s1_dat.a[MSB] != s1_dat.b[MSB]) && (diff[MSB] != s1_dat.a[MSB]);
        sat_hi = !s1_dat.a[MSB];
      end
      OP_PASSA: res = s1_dat.a;
      OP_PASSB: res = s1_dat.b;
      OP_NEGA: begin
        res    = '0 - s1_dat.a;
        ovf    = (s1_dat.a == SMIN);
        sat_hi = 1'b1;
      end
      OP_AND:  res = s1_dat.a & s1_dat.b;
      OP_OR:   res = s1_dat.a | s1_dat.b;
      OP_XOR:  res = s1_dat.a ^ s1_dat.b;
      default: res = '0;
    endcase
    s2_nxt.result = res;
    s2_nxt.carry  = carry;
    s2_nxt.ovf    = ovf;
`ifdef ALU_PIPE_SAT_EN
    if (ovf) begin
      s2_nxt.result = sat_hi ? SMAX : SMIN;
    end
`endif
    s2_nxt.zero = (s2_nxt.result == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_dat     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
      out_zero   <= 1'b0;
    end else begin
      if (accept) begin
        s1_dat.op <= op_e'(in_op);
        s1_dat.a  <= in_a;
        s1_dat.b  <= in_b;
        s1_valid  <= 1'b1;
      end else if (adv1) begin
        s1_valid <= 1'b0;
      end
      // Output registers only move when the current beat is gone, keeping stalled data stable.
      if (adv2) begin
        out_valid  <= s1_valid;
        out_result <= s2_nxt.result;
        out_carry  <= s2_nxt.carry;
        out_ovf    <= s2_nxt.ovf;
        out_zero   <= s2_nxt.zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed vectors queued on accept, monitor pops on each output handshake.
module tb_alu_pipe;
  localparam int W = 16;
`ifdef ALU_PIPE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_ovf;
  logic         out_zero;

  int   checks = 0;
  int   errors = 0;
  int   n_pops = 0;
  vec_t sb[$];
  vec_t vq[$];

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] r, input logic c, input logic o, input logic z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.c = c; v.o = o; v.z = z;
    return v;
  endfunction

  // Monitor: compares every output handshake and checks held beats stay frozen.
  initial begin
    logic          held;
    logic [W+2:0]  held_dat;
    vec_t          e;
    held = 1'b0;
    held_dat = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = 1'b0;
      end else begin
        if (held)
          check("stall hold", {out_valid, out_result, out_carry, out_ovf, out_zero}, {1'b1, held_dat});
        held     = out_valid && !out_ready;
        held_dat = {out_result, out_carry, out_ovf, out_zero};
        if (out_valid && out_ready) begin
          n_pops++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected beat: result %h, none expected", out_result);
          end else begin
            e = sb.pop_front();
            check($sformatf("beat %0d op %0d", n_pops, e.op),
                  {out_result, out_carry, out_ovf, out_zero}, {e.r, e.c, e.o, e.z});
          end
        end
      end
    end
  end

  // Drives vq one beat per cycle, optionally holding out_ready low for a window.
  task automatic run_stream(input int stall_at, input int stall_len, output int dropped, output int gaps);
    int idx = 0;
    int cyc = 0;
    dropped = 0;
    gaps = 0;
    while (idx < vq.size() && cyc < 2000) begin
      @(posedge clk); #1;
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = 1'b1;
      in_op     = vq[idx].op;
      in_a      = vq[idx].a;
      in_b      = vq[idx].b;
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(vq[idx]);
        idx++;
      end else begin
        dropped++;
      end
      if (idx >= 3 && !out_valid) gaps++;
      cyc++;
    end
    if (idx < vq.size()) begin
      checks++;
      errors++;
      $display("FAIL stream timeout: sent %0d of %0d", idx, vq.size());
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("drain empty", sb.size(), 0);
    vq.delete();
  endtask

  initial begin
    int dropped;
    int gaps;
    int pops0;
    logic [W:0] s;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("in_ready during reset", in_ready, 0);
    check("reset outputs", {out_valid, out_result, out_carry, out_ovf, out_zero}, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First beat and its latency
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0003; in_b = 16'h0004; out_ready = 1'b1;
    @(negedge clk);
    check("first in_ready", in_ready, 1);
    if (in_ready) sb.push_back(mk(3'd0, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("no output after 1 edge", out_valid, 0);
    @(negedge clk);
    check("output after 2 edges", out_valid, 1);
    @(negedge clk);

    // Arithmetic boundaries
    vq.push_back(mk(3'd0, 16'h7FFF, 16'h0001, SAT ? 16'h7FFF : 16'h8000, 0, 1, 0));
    vq.push_back(mk(3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0));
    vq.push_back(mk(3'd4, 16'h8000, 16'h0000, SAT ? 16'h7FFF : 16'h8000, 0, 1, 0));
    vq.push_back(mk(3'd0, 16'h8000, 16'hFFFF, SAT ? 16'h8000 : 16'h7FFF, 1, 1, 0));
    vq.push_back(mk(3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1));
    vq.push_back(mk(3'd1, 16'h8000, 16'h0001, SAT ? 16'h8000 : 16'h7FFF, 0, 1, 0));
    run_stream(1000, 0, dropped, gaps);

    // All opcodes with a 5-cycle stall mid-stream
    pops0 = n_pops;
    vq.push_back(mk(3'd0, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0));
    vq.push_back(mk(3'd1, 16'h0005, 16'h0007, 16'hFFFE, 1, 0, 0));
    vq.push_back(mk(3'd2, 16'hABCD, 16'h0001, 16'hABCD, 0, 0, 0));
    vq.push_back(mk(3'd3, 16'h0001, 16'h8000, 16'h8000, 0, 0, 0));
    vq.push_back(mk(3'd4, 16'h0001, 16'h0000, 16'hFFFF, 0, 0, 0));
    vq.push_back(mk(3'd5, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0));
    vq.push_back(mk(3'd6, 16'h0F00, 16'h00F0, 16'h0FF0, 0, 0, 0));
    vq.push_back(mk(3'd7, 16'h5A5A, 16'h5A5A, 16'h0000, 0, 0, 1));
    run_stream(3, 5, dropped, gaps);
    check("in_ready dropped under stall", dropped > 0, 1);
    check("stall stream beat count", n_pops - pops0, 8);

    // Reset with two beats in flight
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0001; in_b = 16'h0001;
    @(negedge clk);
    check("inflight A accepted", in_ready, 1);
    if (in_ready) sb.push_back(mk(3'd0, 16'h0001, 16'h0001, 16'h0002, 0, 0, 0));
    @(posedge clk); #1;
    in_a = 16'h0002; in_b = 16'h0002;
    @(negedge clk);
    check("inflight B accepted", in_ready, 1);
    if (in_ready) sb.push_back(mk(3'd0, 16'h0002, 16'h0002, 16'h0004, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("in_ready low in reset", in_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("out_valid cleared by reset", out_valid, 0);
    pops0 = n_pops;
    @(posedge clk); #1;
    in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0005; in_b = 16'h0006; out_ready = 1'b1;
    @(negedge clk);
    check("accept after reset", in_ready, 1);
    if (in_ready) sb.push_back(mk(3'd0, 16'h0005, 16'h0006, 16'h000B, 0, 0, 0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post-reset no output at 1", out_valid, 0);
    @(negedge clk);
    check("post-reset output at 2", out_valid, 1);
    repeat (3) @(negedge clk);
    check("post-reset single result", n_pops - pops0, 1);

    // 100 back-to-back beats
    pops0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      s = {1'b0, 16'(i << 8)} + {1'b0, 16'hF000};
      vq.push_back(mk(3'd0, 16'(i << 8), 16'hF000, s[W-1:0], s[W], 1'b0, s[W-1:0] == '0));
    end
    run_stream(1000, 0, dropped, gaps);
    check("streaming in_ready stalls", dropped, 0);
    check("streaming output gaps", gaps, 0);
    check("streaming beat count", n_pops - pops0, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, pipelined successor to the 16-bit ALU opcode set: a WIDTH-bit, two-stage ALU with valid/ready handshakes on both sides, full backpressure, and carry/overflow/zero status flags. It keeps the ADD/SUB/PASSA/PASSB/NEGA encodings (3'd0–3'd4) and adds AND/OR/XOR (3'd5–3'd7). It sits between the operand-issue driver and the result consumer, and is the DUT for the ALU scoreboard environments.

## Interface
- WIDTH, 16, operand and result width in bits (≥ 2).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_op  in  3  opcode: 0 ADD, 1 SUB, 2 PASSA, 3 PASSB, 4 NEGA, 5 AND, 6 OR, 7 XOR.
- in_a  in  WIDTH  operand A (two's complement where signed).
- in_b  in  WIDTH  operand B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  result.
- out_carry  out  1  ADD carry-out, or SUB borrow; 0 for other ops.
- out_ovf  out  1  signed overflow for ADD/SUB/NEGA; 0 for other ops.
- out_zero  out  1  out_result == 0.

## Operation
- Stage 1 (S1) registers op, a and b, plus s1_valid. Stage 2 (S2) computes from the S1 registers and registers result, flags and out_valid.
- Advance conditions:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 && !reset
- Accept = in_valid && in_ready.
  - On accept, S1 loads the new beat.
  - Otherwise, when adv1 holds, s1_valid clears.
- When adv2 holds, S2 loads S1's computed result and out_valid ← s1_valid.
- A held beat keeps out_result and the flags stable until out_ready is sampled high.
- Arithmetic is on the WIDTH+1-bit extension:
  - ADD: {carry, result} = a + b. ovf = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]).
  - SUB: result = a − b. carry = (a < b) unsigned. ovf = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
  - NEGA: result = −a (two's complement). ovf = (a == 1 followed by WIDTH−1 zeros). carry = 0.
  - PASSA / PASSB / AND / OR / XOR: bitwise or pass-through result; carry = ovf = 0.
- zero is computed on the final result, after saturation if it is compiled in.
- Order is strictly in-order; no beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+2, given no stall.
- Throughput: 1 beat/cycle while out_ready = 1.
- Backpressure with both stages full and out_ready = 0: in_ready = 0 in the same cycle (combinational path from out_ready).
- Simultaneous events: consume and accept in the same cycle with the pipe full is legal and keeps full throughput.
- Reset values (applied on the edge where reset = 1): s1_valid, out_valid, out_result, out_carry, out_ovf and out_zero all 0. in_ready is 0 while reset is high.
- Reset mid-operation: all in-flight beats are discarded and no partial beat emerges. The first accept is possible in the cycle after reset deasserts.
- out_valid must not drop without a handshake. Data must not change while out_valid && !out_ready.

## Configuration
- ALU_PIPE_SAT_EN defined: when ovf = 1 for ADD/SUB/NEGA, the result clamps to the signed extreme and out_ovf stays 1.
  - Clamp to max (0 followed by ones) when the true result is positive.
  - Clamp to min (1 followed by zeros) otherwise. NEGA of min clamps to max.
- ALU_PIPE_SAT_EN undefined: results wrap modulo 2^WIDTH and flags are identical.
- The macro has no effect on AND/OR/XOR/PASS or on timing.

## Test plan
- Reset, then a single ADD a=16'h0003, b=16'h0004 with out_ready=1 → two cycles later: result 16'h0007, carry 0, ovf 0, zero 0.
- ADD 16'h7FFF + 16'h0001 → ovf 1, carry 0. Result 16'h8000 without ALU_PIPE_SAT_EN; 16'h7FFF with it.
- SUB 16'h0000 − 16'h0001 → result 16'hFFFF, carry 1, ovf 0. NEGA 16'h8000 → ovf 1; result 16'h8000 without saturation, 16'h7FFF with it.
- Stream of 8 beats (all opcodes, XOR a=b → zero 1) with out_ready held 0 for 5 cycles mid-stream → in_ready drops once two beats are held; all 8 results arrive in order, none lost or duplicated, output stable while stalled.
- Assert reset for 1 cycle while 2 beats are in flight → out_valid 0 on the next cycle; the next accepted beat produces exactly one result at latency 2.
- Back-to-back 100 beats with out_ready=1 → one result per cycle after the initial 2-cycle latency; in_ready stays 1 throughout.
